// File: rtl/dccm_arb.sv
// Shares the single DCCM macro between the LSU and DMA requesters; LSU has priority, DMA is protected by a starvation counter.
// Latency: request to DCCM port is combinational (0 cycles); read data returns to the issuing requester 1 cycle after its grant.
// Backpressure: ready is computed each cycle from both requests; a denied requester holds its request until ready=1.
module dccm_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        lsu_req_valid,
    input  logic        lsu_req_we,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_req_ready,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_data,

    input  logic        dma_req_valid,
    input  logic        dma_req_we,
    input  logic [31:0] dma_req_addr,
    input  logic [31:0] dma_req_wdata,
    output logic        dma_req_ready,
    output logic        dma_rsp_valid,
    output logic [31:0] dma_rsp_data,

    output logic        dccm_wr_en,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_wr_data,
    output logic        dccm_rd_en,
    output logic [31:0] dccm_rd_addr,
    input  logic [31:0] dccm_rd_data
);

    logic [CNT_W-1:0] starve_cnt;
    logic             rsp_pend;
    logic             rd_owner;   // 0 = LSU, 1 = DMA

    logic lsu_gnt;
    logic dma_gnt;
    logic dual_ok;
    logic dma_wins;

    // Grant decision: a write/read pair to different words can share the macro, anything else is a conflict.
    always_comb begin
        dual_ok  = lsu_req_valid && dma_req_valid &&
                   (lsu_req_we != dma_req_we) &&
                   (lsu_req_addr[31:2] != dma_req_addr[31:2]);
        dma_wins = (starve_cnt == CNT_W'(STARVE_LIMIT));
        lsu_gnt  = rst_n && lsu_req_valid && (!dma_req_valid || dual_ok || !dma_wins);
        dma_gnt  = rst_n && dma_req_valid && (!lsu_req_valid || dual_ok || dma_wins);
    end

    assign lsu_req_ready = lsu_gnt;
    assign dma_req_ready = dma_gnt;

    // DCCM port steering: at most one write and one read are granted per cycle; idle ports are driven to zero.
    always_comb begin
        dccm_wr_en   = 1'b0;
        dccm_wr_addr = '0;
        dccm_wr_data = '0;
        dccm_rd_en   = 1'b0;
        dccm_rd_addr = '0;
        if (lsu_gnt && lsu_req_we) begin
            dccm_wr_en   = 1'b1;
            dccm_wr_addr = lsu_req_addr;
            dccm_wr_data = lsu_req_wdata;
        end else if (dma_gnt && dma_req_we) begin
            dccm_wr_en   = 1'b1;
            dccm_wr_addr = dma_req_addr;
            dccm_wr_data = dma_req_wdata;
        end
        if (lsu_gnt && !lsu_req_we) begin
            dccm_rd_en   = 1'b1;
            dccm_rd_addr = lsu_req_addr;
        end else if (dma_gnt && !dma_req_we) begin
            dccm_rd_en   = 1'b1;
            dccm_rd_addr = dma_req_addr;
        end
    end

    // Starvation counter: counts consecutive cycles a valid DMA request is denied, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dma_req_valid || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Remember who issued this cycle's read so next cycle's macro data goes back to them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rsp_pend <= dccm_rd_en;
            rd_owner <= dma_gnt && !dma_req_we;
        end
    end

    // Response steering; gating with rst_n drops a response whose read was granted just before reset.
    always_comb begin
        lsu_rsp_valid = rst_n && rsp_pend && !rd_owner;
        dma_rsp_valid = rst_n && rsp_pend && rd_owner;
        lsu_rsp_data  = lsu_rsp_valid ? dccm_rd_data : 32'h0;
        dma_rsp_data  = dma_rsp_valid ? dccm_rd_data : 32'h0;
    end

endmodule

// File: tb/tb_dccm_arb.sv
// Directed bench for dccm_arb: each step drives inputs just after a rising edge and checks outputs mid-cycle.
// Combinational checks see the current request; response checks see the read granted in the previous cycle.
// Uses STARVE_LIMIT=4, so DMA must win the fifth consecutive read conflict.
module tb_dccm_arb;

    logic        clk;
    logic        rst_n;
    logic        lsu_req_valid, lsu_req_we;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic        lsu_req_ready, lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        dma_req_valid, dma_req_we;
    logic [31:0] dma_req_addr, dma_req_wdata;
    logic        dma_req_ready, dma_rsp_valid;
    logic [31:0] dma_rsp_data;
    logic        dccm_wr_en, dccm_rd_en;
    logic [31:0] dccm_wr_addr, dccm_wr_data, dccm_rd_addr, dccm_rd_data;

    int total = 0;
    int bad   = 0;

    dccm_arb #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .dma_req_valid (dma_req_valid),
        .dma_req_we    (dma_req_we),
        .dma_req_addr  (dma_req_addr),
        .dma_req_wdata (dma_req_wdata),
        .dma_req_ready (dma_req_ready),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_data  (dma_rsp_data),
        .dccm_wr_en    (dccm_wr_en),
        .dccm_wr_addr  (dccm_wr_addr),
        .dccm_wr_data  (dccm_wr_data),
        .dccm_rd_en    (dccm_rd_en),
        .dccm_rd_addr  (dccm_rd_addr),
        .dccm_rd_data  (dccm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0;
        dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    endtask

    task automatic lsu_rd(input logic [31:0] a);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = a; lsu_req_wdata = '0;
    endtask

    task automatic dma_rd(input logic [31:0] a);
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = a; dma_req_wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        dccm_rd_data = 32'h0;
        idle();

        // ---- Reset state: request present but nothing may be granted or driven
        next_cycle();
        lsu_rd(32'h100);
        #1;
        chk("rst_lsu_ready", {31'b0, lsu_req_ready}, 32'h0);
        chk("rst_rd_en",     {31'b0, dccm_rd_en}, 32'h0);
        chk("rst_rd_addr",   dccm_rd_addr, 32'h0);
        chk("rst_lsu_rsp_v", {31'b0, lsu_rsp_valid}, 32'h0);
        next_cycle();
        chk("rst_starve",    32'(dut.starve_cnt), 32'h0);
        rst_n = 1'b1;
        idle();

        // ---- LSU read-only
        next_cycle();
        lsu_rd(32'h100);
        #1;
        chk("rd_lsu_ready", {31'b0, lsu_req_ready}, 32'h1);
        chk("rd_rd_en",     {31'b0, dccm_rd_en}, 32'h1);
        chk("rd_rd_addr",   dccm_rd_addr, 32'h100);
        chk("rd_wr_en",     {31'b0, dccm_wr_en}, 32'h0);
        next_cycle();
        idle();
        dccm_rd_data = 32'hDEADBEEF;
        #1;
        chk("rd_lsu_rsp_v", {31'b0, lsu_rsp_valid}, 32'h1);
        chk("rd_lsu_rsp_d", lsu_rsp_data, 32'hDEADBEEF);
        chk("rd_dma_rsp_v", {31'b0, dma_rsp_valid}, 32'h0);
        chk("rd_dma_rsp_d", dma_rsp_data, 32'h0);
        next_cycle();
        chk("rd_lsu_rsp_idle", {31'b0, lsu_rsp_valid}, 32'h0);
        chk("rd_lsu_dat_idle", lsu_rsp_data, 32'h0);

        // ---- Dual grant: LSU write + DMA read to different words
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h200; lsu_req_wdata = 32'h11223344;
        dma_rd(32'h300);
        #1;
        chk("dual_lsu_ready", {31'b0, lsu_req_ready}, 32'h1);
        chk("dual_dma_ready", {31'b0, dma_req_ready}, 32'h1);
        chk("dual_wr_en",     {31'b0, dccm_wr_en}, 32'h1);
        chk("dual_wr_addr",   dccm_wr_addr, 32'h200);
        chk("dual_wr_data",   dccm_wr_data, 32'h11223344);
        chk("dual_rd_en",     {31'b0, dccm_rd_en}, 32'h1);
        chk("dual_rd_addr",   dccm_rd_addr, 32'h300);
        next_cycle();
        idle();
        dccm_rd_data = 32'hCAFE0001;
        #1;
        chk("dual_dma_rsp_v", {31'b0, dma_rsp_valid}, 32'h1);
        chk("dual_dma_rsp_d", dma_rsp_data, 32'hCAFE0001);
        chk("dual_lsu_rsp_v", {31'b0, lsu_rsp_valid}, 32'h0);
        chk("dual_lsu_rsp_d", lsu_rsp_data, 32'h0);

        // ---- Same-word conflict: LSU read 0x204 vs DMA write 0x206
        next_cycle();
        lsu_rd(32'h204);
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 32'h206; dma_req_wdata = 32'h55;
        #1;
        chk("conf_lsu_ready", {31'b0, lsu_req_ready}, 32'h1);
        chk("conf_dma_ready", {31'b0, dma_req_ready}, 32'h0);
        chk("conf_wr_en",     {31'b0, dccm_wr_en}, 32'h0);
        chk("conf_wr_addr",   dccm_wr_addr, 32'h0);
        chk("conf_rd_addr",   dccm_rd_addr, 32'h204);
        next_cycle();
        lsu_req_valid = 1'b0; lsu_req_addr = '0;
        dccm_rd_data = 32'h0BADF00D;
        #1;
        chk("conf_starve1",    32'(dut.starve_cnt), 32'h1);
        chk("conf_dma_ready2", {31'b0, dma_req_ready}, 32'h1);
        chk("conf_wr_en2",     {31'b0, dccm_wr_en}, 32'h1);
        chk("conf_wr_addr2",   dccm_wr_addr, 32'h206);
        chk("conf_wr_data2",   dccm_wr_data, 32'h55);
        chk("conf_lsu_rsp_d",  lsu_rsp_data, 32'h0BADF00D);
        next_cycle();
        idle();
        #1;
        chk("conf_starve0",    32'(dut.starve_cnt), 32'h0);
        chk("conf_no_rsp",     {31'b0, dma_rsp_valid}, 32'h0);

        // ---- Starvation: both read every cycle; DMA wins the fifth conflict
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            lsu_rd(32'h10);
            dma_rd(32'h20);
            dccm_rd_data = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("starve_cnt_c%0d", k), 32'(dut.starve_cnt), (k == 6) ? 32'h0 : 32'(k - 1));
            chk($sformatf("starve_lsu_rdy_c%0d", k), {31'b0, lsu_req_ready}, (k == 5) ? 32'h0 : 32'h1);
            chk($sformatf("starve_dma_rdy_c%0d", k), {31'b0, dma_req_ready}, (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("starve_rd_addr_c%0d", k), dccm_rd_addr, (k == 5) ? 32'h20 : 32'h10);
            if (k >= 2) begin
                chk($sformatf("starve_dma_rsp_c%0d", k), {31'b0, dma_rsp_valid}, (k == 6) ? 32'h1 : 32'h0);
            end
            next_cycle();
        end
        idle();

        // ---- Reset mid-read: LSU read granted (DMA denied, counter -> 1), then reset asserted
        next_cycle();
        lsu_rd(32'h100);
        dma_rd(32'h140);
        #1;
        chk("mid_lsu_ready", {31'b0, lsu_req_ready}, 32'h1);
        next_cycle();
        rst_n = 1'b0;
        dccm_rd_data = 32'h77777777;
        #1;
        chk("mid_lsu_rsp_v", {31'b0, lsu_rsp_valid}, 32'h0);
        chk("mid_lsu_rsp_d", lsu_rsp_data, 32'h0);
        chk("mid_lsu_ready0", {31'b0, lsu_req_ready}, 32'h0);
        chk("mid_dma_ready0", {31'b0, dma_req_ready}, 32'h0);
        chk("mid_rd_en",     {31'b0, dccm_rd_en}, 32'h0);
        chk("mid_rd_addr",   dccm_rd_addr, 32'h0);
        next_cycle();
        chk("mid_starve",    32'(dut.starve_cnt), 32'h0);
        chk("mid_lsu_rsp_v2", {31'b0, lsu_rsp_valid}, 32'h0);
        rst_n = 1'b1;
        idle();
        #1;
        chk("mid_rsp_after", {31'b0, lsu_rsp_valid | dma_rsp_valid}, 32'h0);
        next_cycle();
        lsu_rd(32'h100);
        #1;
        chk("post_lsu_ready", {31'b0, lsu_req_ready}, 32'h1);
        chk("post_rd_addr",   dccm_rd_addr, 32'h100);
        next_cycle();
        idle();
        dccm_rd_data = 32'hDEADBEEF;
        #1;
        chk("post_lsu_rsp_d", lsu_rsp_data, 32'hDEADBEEF);

        // ---- Back-to-back reads: LSU 0x0 then DMA 0x4
        next_cycle();
        lsu_rd(32'h0);
        #1;
        chk("b2b_rd_en0",  {31'b0, dccm_rd_en}, 32'h1);
        chk("b2b_rd_addr0", dccm_rd_addr, 32'h0);
        next_cycle();
        idle();
        dma_rd(32'h4);
        dccm_rd_data = 32'hA0A0A0A0;
        #1;
        chk("b2b_rd_addr1", dccm_rd_addr, 32'h4);
        chk("b2b_lsu_rsp_v", {31'b0, lsu_rsp_valid}, 32'h1);
        chk("b2b_lsu_rsp_d", lsu_rsp_data, 32'hA0A0A0A0);
        chk("b2b_dma_rsp_v1", {31'b0, dma_rsp_valid}, 32'h0);
        next_cycle();
        idle();
        dccm_rd_data = 32'hB0B0B0B0;
        #1;
        chk("b2b_dma_rsp_v", {31'b0, dma_rsp_valid}, 32'h1);
        chk("b2b_dma_rsp_d", dma_rsp_data, 32'hB0B0B0B0);
        chk("b2b_lsu_rsp_v2", {31'b0, lsu_rsp_valid}, 32'h0);

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
